// File: rtl/lagarto_reset_sequencer_pkg.sv
// Shared types and default parameters for the Lagarto tile reset sequencer.
package lagarto_rst_pkg;

    typedef enum logic [2:0] {
        WAKE,
        RELEASE,
        RUN,
        QUIESCE,
        ASSERT
    } rstseq_state_e;

    localparam int unsigned DEF_NUM_DOMAINS    = 3;
    localparam int unsigned DEF_WAKE_CNT_W     = 16;
    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_STAGGER_CYCLES = 8;
    localparam int unsigned DEF_HOLD_CYCLES    = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/lagarto_reset_sequencer_sync.sv
// Reset synchronizer: asynchronous assertion, deassertion after SYNC_STAGES clock edges.
module lagarto_rst_sync
    import lagarto_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic reset_l,
    output logic reset_sync_l
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign reset_sync_l = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/lagarto_reset_sequencer.sv
// Multi-domain reset/wake-up sequencer with warm-reset quiesce handshake.
// Optional quiesce timeout: define LAGARTO_RSTSEQ_QUIESCE_TIMEOUT_EN.
module lagarto_reset_sequencer
    import lagarto_rst_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int unsigned WAKE_CNT_W     = DEF_WAKE_CNT_W,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk_i,
    input  logic                   reset_l,
    input  logic [63:0]            boot_addr_i,
    output logic [63:0]            boot_addr_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_no,
    output logic                   all_ready_o,
    input  logic                   soft_rst_req_i,
    output logic                   soft_rst_ack_o,
    output logic                   quiesce_req_o,
    input  logic                   quiesce_ack_i,
    output logic                   timeout_o
);

    localparam int unsigned STG_W = $clog2(STAGGER_CYCLES*NUM_DOMAINS+1);
    localparam int unsigned HLD_W = $clog2(HOLD_CYCLES+1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'((NUM_DOMAINS-1)*STAGGER_CYCLES);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES-1);

    if (SYNC_STAGES < 2 || STAGGER_CYCLES < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1)
    begin : g_bad_params
        $error("lagarto_reset_sequencer: illegal parameter value");
    end

    logic rst_sync_l;

    lagarto_rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk_i       (clk_i),
        .reset_l     (reset_l),
        .reset_sync_l(rst_sync_l)
    );

    rstseq_state_e         state_q, state_d;
    logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic [STG_W-1:0]      stg_cnt_q, stg_cnt_d;
    logic [HLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [NUM_DOMAINS-1:0] domain_q, domain_d;
    logic                  ready_q, ready_d;
    logic                  qreq_q, qreq_d;
    logic                  ack_q, ack_d;
    logic [63:0]           boot_q, boot_d;
    logic                  req_q;
    logic                  req_rise;
    logic                  tmo_hit;
    logic                  go_assert;
    logic                  enter_rel;

    // The edge detector tracks in every state so a level held across states is never retaken.
    assign req_rise = soft_rst_req_i & ~req_q;

`ifdef LAGARTO_RSTSEQ_QUIESCE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES-1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;

    assign tmo_hit = (state_q == QUIESCE) && !quiesce_ack_i && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk_i or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == QUIESCE) ? tmo_cnt_q + 1'b1 : '0;
            if (tmo_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        stg_cnt_d  = stg_cnt_q;
        hold_cnt_d = hold_cnt_q;
        domain_d   = domain_q;
        ready_d    = ready_q;
        qreq_d     = qreq_q;
        ack_d      = 1'b0;
        boot_d     = boot_q;
        go_assert  = 1'b0;
        enter_rel  = 1'b0;

        case (state_q)
            WAKE: begin
                if (wake_cnt_q[WAKE_CNT_W-1]) begin
                    enter_rel = 1'b1;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (stg_cnt_q == STG_LAST) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    stg_cnt_d = stg_cnt_q + 1'b1;
                    for (int unsigned k = 1; k < NUM_DOMAINS; k++) begin
                        if (stg_cnt_d == STG_W'(k*STAGGER_CYCLES)) begin
                            domain_d[k] = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (req_rise) begin
                    state_d = QUIESCE;
                    qreq_d  = 1'b1;
                end
            end
            QUIESCE: begin
                go_assert = quiesce_ack_i | tmo_hit;
            end
            ASSERT: begin
                if (hold_cnt_q == HLD_LAST) begin
                    enter_rel = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    ack_d      = (hold_cnt_d == HLD_LAST);
                end
            end
            default: state_d = WAKE;
        endcase

        if (go_assert) begin
            state_d    = ASSERT;
            domain_d   = '0;
            qreq_d     = 1'b0;
            ready_d    = 1'b0;
            hold_cnt_d = '0;
            ack_d      = (HOLD_CYCLES == 1);
        end

        // Domain 0 is released on the same edge that enters RELEASE.
        if (enter_rel) begin
            state_d     = RELEASE;
            boot_d      = boot_addr_i;
            stg_cnt_d   = '0;
            domain_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state_q    <= WAKE;
            wake_cnt_q <= '0;
            stg_cnt_q  <= '0;
            hold_cnt_q <= '0;
            domain_q   <= '0;
            ready_q    <= 1'b0;
            qreq_q     <= 1'b0;
            ack_q      <= 1'b0;
            boot_q     <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            stg_cnt_q  <= stg_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            domain_q   <= domain_d;
            ready_q    <= ready_d;
            qreq_q     <= qreq_d;
            ack_q      <= ack_d;
            boot_q     <= boot_d;
            req_q      <= soft_rst_req_i;
        end
    end

    assign boot_addr_o    = boot_q;
    assign domain_rst_no  = domain_q;
    assign all_ready_o    = ready_q;
    assign quiesce_req_o  = qreq_q;
    assign soft_rst_ack_o = ack_q;

endmodule

// File: doc/lagarto_reset_sequencer.md
# lagarto_reset_sequencer

Parametrised reset/wake-up sequencer for the Lagarto tile. It replaces the fixed 16-bit wake-up counter and single synchronizer in the tile wrapper with a multi-domain controller. After power-on it releases N reset domains (e.g. CSR file, core, L1.5 adapter) in a staggered order, and it supports a software-requested warm reset with a quiesce handshake. It sits between the OpenPiton tile reset and every Lagarto sub-block reset input.

## Interface
- NUM_DOMAINS, 3, number of independent reset outputs; domain 0 is released first.
- WAKE_CNT_W, 16, wake-up counter width; the wake-up delay is 2^(WAKE_CNT_W-1) cycles.
- SYNC_STAGES, 2, reset synchronizer depth (≥2).
- STAGGER_CYCLES, 8, cycles between consecutive domain releases (≥1).
- HOLD_CYCLES, 16, cycles all domains are held in reset during a warm reset (≥1).
- TIMEOUT_CYCLES, 1024, quiesce timeout; meaningful only with the timeout macro.

Ports:
- clk_i  in  1  core clock.
- reset_l  in  1  tile reset. Asynchronous, active-low. This is the single clock/reset pair of the block.
- boot_addr_i  in  64  boot address, sampled on entry to RELEASE.
- boot_addr_o  out  64  latched boot address; reset value 0.
- domain_rst_no  out  NUM_DOMAINS  per-domain active-low reset; reset value all 0.
- all_ready_o  out  1  all domains released (state RUN); reset value 0.
- soft_rst_req_i  in  1  warm-reset request (level; rising edge taken).
- soft_rst_ack_o  out  1  one-cycle pulse when the warm reset completes its hold; reset value 0.
- quiesce_req_o  out  1  asks the memory side to drain; reset value 0.
- quiesce_ack_i  in  1  memory side idle.
- timeout_o  out  1  sticky flag: a quiesce timed out; reset value 0.

## Operation
- reset_l passes through the synchronizer sub-module: assertion is asynchronous, deassertion is synchronous after SYNC_STAGES edges. All state uses this internal reset.
- **WAKE**: the wake counter increments by 1 per cycle from 0. When the counter MSB is set, the counter saturates (no wrap) and the FSM moves to RELEASE.
- **RELEASE**:
  - On entry, boot_addr_o <= boot_addr_i and the stagger counter is cleared.
  - Domain k deasserts (goes to 1) exactly k*STAGGER_CYCLES cycles after entry. Released domains stay released.
  - One cycle after the last domain is released, the FSM moves to RUN.
- **RUN**:
  - all_ready_o = 1.
  - A rising edge of soft_rst_req_i (registered edge detect) moves the FSM to QUIESCE.
  - Rising edges seen in any other state are dropped. The edge-detect register keeps tracking, so a request held high across states is not retaken.
- **QUIESCE**: quiesce_req_o = 1. When quiesce_ack_i = 1 is sampled, the FSM moves to ASSERT.
- **ASSERT**:
  - All domain_rst_no = 0 in the same cycle; quiesce_req_o = 0; all_ready_o = 0.
  - The FSM holds for HOLD_CYCLES cycles.
  - On the last hold cycle, soft_rst_ack_o pulses for one cycle, and the FSM goes to RELEASE (not WAKE).
- reset_l assertion in any state immediately forces all outputs to their reset values and the FSM to WAKE. The wake counter restarts from 0.
- quiesce_ack_i is ignored outside QUIESCE.
- If soft_rst_req_i and quiesce_ack_i are both high on the RUN→QUIESCE cycle, the ack is sampled only in QUIESCE, one cycle later at the earliest.

## Timing
- Outputs are registered; nothing is driven combinationally from the inputs.
- Power-on release of domain 0 occurs SYNC_STAGES + 2^(WAKE_CNT_W-1) + 1 cycles after reset_l rises (±0).
- Domain k is released STAGGER_CYCLES*k cycles after domain 0.
- all_ready_o rises 1 cycle after the last domain is released.
- QUIESCE→ASSERT: 1 cycle after quiesce_ack_i is sampled high.
- Warm reset: domain 0 is released 1 cycle after the soft_rst_ack_o pulse.

## Configuration
- `LAGARTO_RSTSEQ_QUIESCE_TIMEOUT_EN` defined:
  - A TIMEOUT_CYCLES counter runs in QUIESCE.
  - On expiry without ack, the FSM moves to ASSERT and timeout_o is set.
  - timeout_o is cleared only by reset_l.
- Undefined: QUIESCE waits indefinitely, timeout_o is tied to 0, and the counter logic is absent.

## Structure
- Package `lagarto_rst_pkg`: the state enum rstseq_state_e {WAKE, RELEASE, RUN, QUIESCE, ASSERT} and default parameter constants.
- One sub-module: `lagarto_rst_sync`. It is a parametrised SYNC_STAGES flop chain giving asynchronous assert and synchronous deassert.
- Counter widths:
  - Stagger counter: $clog2(STAGGER_CYCLES*NUM_DOMAINS+1).
  - Hold counter: $clog2(HOLD_CYCLES+1).
  - Timeout counter: $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Power-on, with WAKE_CNT_W=4, SYNC_STAGES=2, STAGGER_CYCLES=3, NUM_DOMAINS=3, boot_addr_i=0x8000_0000.
  - domain_rst_no goes 001 at cycle 11, 011 at 14, 111 at 17.
  - all_ready_o = 1 at 18; boot_addr_o = 0x8000_0000.
- Warm reset with HOLD_CYCLES=4: rising edge on soft_rst_req_i in RUN, quiesce_ack_i asserted 5 cycles later.
  - ASSERT follows 1 cycle after the ack; domains are 000 for 4 cycles.
  - soft_rst_ack_o pulses once, then the staggered release repeats without WAKE.
- soft_rst_req_i held high from RELEASE into RUN → no warm reset is taken. A fresh edge in RUN → QUIESCE.
- reset_l dropped mid-QUIESCE → all outputs 0 in the same cycle, and quiesce_req_o = 0. The full power-on sequence reruns.
- With the macro defined and TIMEOUT_CYCLES=8, quiesce_ack_i tied to 0 → ASSERT after 8 cycles and timeout_o = 1, held until reset_l.
- Without the macro, ack withheld for 2000 cycles → the FSM stays in QUIESCE and timeout_o stays 0.
